// File: rtl/pic_buf_ctrl.sv
// Picture line-buffer controller: fills a 4-row window buffer from memory,
// slides a 4x4 window across each 4-row band, then shifts the buffer and
// loads the next image row until every band of the image has been covered.
module pic_buf_ctrl #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              buf_we,
  output logic              buf_re,
  output logic              buf_shift,
  output logic [1:0]        buf_i,
  output logic [3:0]        buf_j,
  output logic              win_valid,
  input  logic              win_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SLIDE = 3'd2,
    SHIFT = 3'd3,
    LOAD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Index of the band whose last window ends the image.
  localparam logic [5:0] LAST_BAND = 6'(ROWS - 4);

  state_t      state, state_nx;
  logic [5:0]  row, row_nx;
  logic [1:0]  word, word_nx;
  logic [3:0]  col, col_nx;
  logic [5:0]  band, band_nx;
  logic [ADDR_W-1:0] word_addr;

  // Word address of the current row/word; {row, word} is exactly 4*row + word.
  assign word_addr = ADDR_W'(BASE) + ADDR_W'({row, word});

  // State and counter registers; reset drops any outstanding read at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      word  <= '0;
      col   <= '0;
      band  <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      word  <= word_nx;
      col   <= col_nx;
      band  <= band_nx;
    end
  end

  // Next-state, counter updates and all outputs decoded from the current state.
  always_comb begin
    state_nx  = state;
    row_nx    = row;
    word_nx   = word;
    col_nx    = col;
    band_nx   = band;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    buf_shift = 1'b0;
    buf_i     = 2'd0;
    buf_j     = 4'd0;
    win_valid = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FILL;
          row_nx   = '0;
          word_nx  = '0;
          col_nx   = '0;
          band_nx  = '0;
        end
      end

      FILL: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = word_addr;
        buf_we   = mem_valid;
        buf_i    = row[1:0];
        buf_j    = {word, 2'b00};
        if (mem_valid) begin
          word_nx = word + 2'd1;
          if (word == 2'd3) begin
            if (row == 6'd3) begin
              state_nx = SLIDE;
              col_nx   = 4'd3;
            end else begin
              row_nx = row + 6'd1;
            end
          end
        end
      end

      SLIDE: begin
        busy      = 1'b1;
        buf_re    = 1'b1;
        win_valid = 1'b1;
        buf_j     = col;
        if (win_ready) begin
          if (col == 4'd15) begin
            state_nx = (band == LAST_BAND) ? DONE : SHIFT;
          end else begin
            col_nx = col + 4'd1;
          end
        end
      end

      SHIFT: begin
        busy      = 1'b1;
        buf_shift = 1'b1;
        state_nx  = LOAD;
        band_nx   = band + 6'd1;
        row_nx    = row + 6'd1;
        word_nx   = '0;
      end

      LOAD: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = word_addr;
        buf_we   = mem_valid;
        buf_i    = 2'd3;
        buf_j    = {word, 2'b00};
        if (mem_valid) begin
          word_nx = word + 2'd1;
          if (word == 2'd3) begin
            state_nx = SLIDE;
            col_nx   = 4'd3;
          end
        end
      end

      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pic_buf_ctrl.sv
// Self-checking bench for pic_buf_ctrl: two instances (ROWS=4/BASE=0 and
// ROWS=6/BASE=8) are checked every cycle against a step-list model of the
// image traversal, plus hand-computed totals and addresses.
module tb_pic_buf_ctrl;

  logic clk = 1'b0;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic       start[2];
  logic       mem_valid[2];
  logic       win_ready[2];
  logic       busy[2];
  logic       done[2];
  logic       mem_rd[2];
  logic       buf_we[2];
  logic       buf_re[2];
  logic       buf_shift[2];
  logic       win_valid[2];
  logic [7:0] mem_addr[2];
  logic [1:0] buf_i[2];
  logic [3:0] buf_j[2];

  pic_buf_ctrl #(.ROWS(4), .ADDR_W(8), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_valid(mem_valid[0]),
    .buf_we(buf_we[0]), .buf_re(buf_re[0]), .buf_shift(buf_shift[0]),
    .buf_i(buf_i[0]), .buf_j(buf_j[0]), .win_valid(win_valid[0]), .win_ready(win_ready[0])
  );

  pic_buf_ctrl #(.ROWS(6), .ADDR_W(8), .BASE(8)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_valid(mem_valid[1]),
    .buf_we(buf_we[1]), .buf_re(buf_re[1]), .buf_shift(buf_shift[1]),
    .buf_i(buf_i[1]), .buf_j(buf_j[1]), .win_valid(win_valid[1]), .win_ready(win_ready[1])
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point: every check in the bench steps these counters.
  task automatic checkOutput(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Image geometry of each instance, as seen by the model.
  int rowsOf[2] = '{4, 6};
  int baseOf[2] = '{0, 8};

  // Model: an image is a flat list of steps. Kind 0 = memory read, 1 = window,
  // 2 = buffer shift, 3 = done. Step k is computed by plain arithmetic.
  task automatic stepInfo(input int rows, input int base, input int k,
                          output int kind, output int addr, output int bi, output int bj);
    int o, b, off;
    kind = 3; addr = 0; bi = 0; bj = 0;
    if (k < 16) begin
      kind = 0; addr = (base + k) % 256; bi = k / 4; bj = 4 * (k % 4);
    end else if (k < 29) begin
      kind = 1; bj = k - 16 + 3;
    end else begin
      o = k - 29;
      b = o / 18;
      off = o % 18;
      if (b < rows - 4) begin
        if (off == 0) begin
          kind = 2;
        end else if (off <= 4) begin
          kind = 0; addr = (base + 4 * (b + 4) + off - 1) % 256; bi = 3; bj = 4 * (off - 1);
        end else begin
          kind = 1; bj = off - 2;
        end
      end
    end
  endtask

  bit active[2];
  int step[2];

  // One model cycle for instance n: compare the DUT against the current step,
  // then advance the step according to the handshake inputs of this cycle.
  task automatic modelCycle(input int n);
    int kind, addr, bi, bj;
    logic [6:0] ctlGot, ctlExp;
    ctlGot = {busy[n], done[n], mem_rd[n], buf_we[n], buf_re[n], buf_shift[n], win_valid[n]};
    if (!rst_n[n]) begin
      active[n] = 1'b0;
      checkOutput($sformatf("dut%0d_reset_outputs", n), {ctlGot, mem_addr[n], buf_i[n], buf_j[n]}, 0);
      return;
    end
    if (!active[n]) begin
      checkOutput($sformatf("dut%0d_idle_ctl", n), ctlGot, 0);
      if (start[n]) begin
        active[n] = 1'b1;
        step[n] = 0;
      end
      return;
    end
    stepInfo(rowsOf[n], baseOf[n], step[n], kind, addr, bi, bj);
    case (kind)
      0: ctlExp = {1'b1, 1'b0, 1'b1, mem_valid[n], 3'b000};
      1: ctlExp = 7'b1000101;
      2: ctlExp = 7'b1000010;
      default: ctlExp = 7'b0100000;
    endcase
    checkOutput($sformatf("dut%0d_step%0d_ctl", n, step[n]), ctlGot, ctlExp);
    if (kind == 0) begin
      checkOutput($sformatf("dut%0d_step%0d_addr", n, step[n]), mem_addr[n], addr);
      checkOutput($sformatf("dut%0d_step%0d_buf_i", n, step[n]), buf_i[n], bi);
    end
    if (kind == 0 || kind == 1)
      checkOutput($sformatf("dut%0d_step%0d_buf_j", n, step[n]), buf_j[n], bj);
    case (kind)
      0: if (mem_valid[n]) step[n]++;
      1: if (win_ready[n]) step[n]++;
      2: step[n]++;
      default: active[n] = 1'b0;
    endcase
  endtask

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) modelCycle(n);
    end
  end

  int reads[2], wins[2], shifts[2], dones[2], wes[2], rdCycles[2], j7Cycles[2];
  logic [7:0] wqA[$];
  logic [7:0] wqB[$];

  // Event counters and write-address log, used for hand-computed totals.
  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (rst_n[n]) begin
          if (mem_rd[n] && mem_valid[n]) reads[n]++;
          if (win_valid[n] && win_ready[n]) wins[n]++;
          if (buf_shift[n]) shifts[n]++;
          if (done[n]) dones[n]++;
          if (mem_rd[n]) rdCycles[n]++;
          if (win_valid[n] && buf_j[n] == 4'd7) j7Cycles[n]++;
          if (buf_we[n]) begin
            wes[n]++;
            if (n == 0) wqA.push_back(mem_addr[n]);
            else wqB.push_back(mem_addr[n]);
          end
        end
      end
    end
  end

  bit tie[2];
  int delay[2];
  int stallJ[2];
  int stallLeft[2];
  int age[2];
  bit accLast[2];

  // Memory and consumer responders: mem_valid either tied high or raised after
  // 'delay' wait cycles per request; win_ready drops for stallLeft cycles at stallJ.
  initial begin
    mem_valid = '{1'b0, 1'b0};
    win_ready = '{1'b1, 1'b1};
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) accLast[n] = mem_rd[n] && mem_valid[n];
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (tie[n]) begin
          mem_valid[n] = 1'b1;
          age[n] = 0;
        end else if (!mem_rd[n]) begin
          mem_valid[n] = 1'b0;
          age[n] = 0;
        end else begin
          if (accLast[n]) age[n] = 0;
          mem_valid[n] = (age[n] >= delay[n]);
          age[n]++;
        end
        if (win_valid[n] && buf_j[n] == 4'(stallJ[n]) && stallLeft[n] > 0) begin
          win_ready[n] = 1'b0;
          stallLeft[n] = stallLeft[n] - 1;
        end else begin
          win_ready[n] = 1'b1;
        end
      end
    end
  end

  // One-cycle start pulse for instance n.
  task automatic applyStimulus(input int n);
    @(posedge clk);
    #1 start[n] = 1'b1;
    @(posedge clk);
    #1 start[n] = 1'b0;
  endtask

  // Bounded wait for the done pulse; a timeout counts as a failed check.
  task automatic waitDone(input int n, input int maxCycles);
    bit found;
    found = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      if (done[n]) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("dut%0d_done_seen", n), found, 1);
  endtask

  int sReads[2], sWins[2], sShifts[2], sDones[2], sWes[2], sRd[2], sJ7[2];
  int qBase;

  // Remember the counters so an image's totals can be taken as differences.
  task automatic takeSnapshot(input int n);
    sReads[n] = reads[n]; sWins[n] = wins[n]; sShifts[n] = shifts[n];
    sDones[n] = dones[n]; sWes[n] = wes[n]; sRd[n] = rdCycles[n]; sJ7[n] = j7Cycles[n];
    qBase = (n == 0) ? wqA.size() : wqB.size();
  endtask

  // Directed scenarios, each closed by hand-computed totals.
  initial begin
    bit found;
    rst_n = '{1'b0, 1'b0};
    start = '{1'b0, 1'b0};
    tie = '{1'b1, 1'b1};
    delay = '{0, 0};
    stallJ = '{-1, -1};
    stallLeft = '{0, 0};
    repeat (3) @(posedge clk);
    #3 rst_n = '{1'b1, 1'b1};
    repeat (2) @(posedge clk);

    // ROWS=4, everything tied high: 16 back-to-back reads, 13 windows, no shift.
    takeSnapshot(0);
    applyStimulus(0);
    waitDone(0, 200);
    repeat (3) @(negedge clk);
    checkOutput("a_reads", reads[0] - sReads[0], 16);
    checkOutput("a_writes", wes[0] - sWes[0], 16);
    checkOutput("a_rd_cycles", rdCycles[0] - sRd[0], 16);
    checkOutput("a_windows", wins[0] - sWins[0], 13);
    checkOutput("a_shifts", shifts[0] - sShifts[0], 0);
    checkOutput("a_dones", dones[0] - sDones[0], 1);
    checkOutput("a_first_addr", wqA[qBase], 0);
    checkOutput("a_last_addr", wqA[qBase + 15], 15);

    // Consumer stalls five cycles at j=7: six cycles presenting j=7.
    tie[0] = 1'b0;
    stallJ[0] = 7;
    stallLeft[0] = 5;
    takeSnapshot(0);
    applyStimulus(0);
    waitDone(0, 200);
    repeat (3) @(negedge clk);
    checkOutput("a_stall_j7_cycles", j7Cycles[0] - sJ7[0], 6);
    checkOutput("a_stall_windows", wins[0] - sWins[0], 13);
    checkOutput("a_stall_reads", reads[0] - sReads[0], 16);

    // ROWS=6, BASE=8, extra start pulses while busy must be ignored.
    takeSnapshot(1);
    applyStimulus(1);
    repeat (3) begin
      repeat (12) @(posedge clk);
      applyStimulus(1);
    end
    waitDone(1, 300);
    repeat (5) @(negedge clk);
    checkOutput("b_windows", wins[1] - sWins[1], 39);
    checkOutput("b_reads", reads[1] - sReads[1], 24);
    checkOutput("b_shifts", shifts[1] - sShifts[1], 2);
    checkOutput("b_dones", dones[1] - sDones[1], 1);
    checkOutput("b_idle_after", busy[1], 0);
    checkOutput("b_j7_cycles", j7Cycles[1] - sJ7[1], 3);
    checkOutput("b_first_addr", wqB[qBase], 8);
    checkOutput("b_load1_first", wqB[qBase + 16], 24);
    checkOutput("b_load1_last", wqB[qBase + 19], 27);
    checkOutput("b_load2_first", wqB[qBase + 20], 28);
    checkOutput("b_load2_last", wqB[qBase + 23], 31);

    // mem_valid three cycles late: four cycles of mem_rd per word.
    tie[1] = 1'b0;
    delay[1] = 3;
    takeSnapshot(1);
    applyStimulus(1);
    waitDone(1, 500);
    repeat (3) @(negedge clk);
    checkOutput("b_slow_rd_cycles", rdCycles[1] - sRd[1], 96);
    checkOutput("b_slow_reads", reads[1] - sReads[1], 24);
    checkOutput("b_slow_writes", wes[1] - sWes[1], 24);
    checkOutput("b_slow_windows", wins[1] - sWins[1], 39);

    // Reset in the middle of a LOAD request, then a fresh image from BASE.
    applyStimulus(1);
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mem_rd[1] && mem_addr[1] >= 8'd24) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("b_reached_load", found, 1);
    @(negedge clk);
    checkOutput("b_mid_load_rd", mem_rd[1], 1);
    #2 rst_n[1] = 1'b0;
    tie[1] = 1'b1;
    #1;
    checkOutput("b_reset_now", {busy[1], done[1], mem_rd[1], buf_we[1], buf_re[1], buf_shift[1],
                                win_valid[1], mem_addr[1], buf_i[1], buf_j[1]}, 0);
    repeat (3) @(posedge clk);
    #3 rst_n[1] = 1'b1;
    repeat (3) @(posedge clk);
    tie[1] = 1'b0;
    delay[1] = 1;
    takeSnapshot(1);
    applyStimulus(1);
    waitDone(1, 500);
    repeat (3) @(negedge clk);
    checkOutput("b_restart_first_addr", wqB[qBase], 8);
    checkOutput("b_restart_reads", reads[1] - sReads[1], 24);
    checkOutput("b_restart_windows", wins[1] - sWins[1], 39);
    checkOutput("b_restart_dones", dones[1] - sDones[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case a scenario never returns.
  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_buf_ctrl.md
PIC_BUF_CTRL -- requirements
Module: pic_buf_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 16, giving the image height in rows (legal range 4..64); the image width is fixed at 16 bytes, i.e. 4 words of 32 bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the memory word-address width (2^ADDR_W >= ROWS*4).
REQ-003 The block SHALL have parameter BASE, default 0, giving the word address of image row 0, word 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to process one image.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse after the last window is accepted.
REQ-009 mem_rd  output  1  memory read request; held high until mem_valid.
REQ-010 mem_addr  output  ADDR_W  word address; stable while mem_rd is high.
REQ-011 mem_valid  input  1  read data valid this cycle; completes the request.
REQ-012 buf_we  output  1  buffer write enable.
REQ-013 buf_re  output  1  buffer read enable.
REQ-014 buf_shift  output  1  buffer row-shift strobe.
REQ-015 buf_i  output  2  buffer row index.
REQ-016 buf_j  output  4  buffer column index.
REQ-017 win_valid  output  1  a 4x4 window is present on the buffer output.
REQ-018 win_ready  input  1  the consumer accepts the window this cycle.

Function
REQ-019 The FSM SHALL have the states IDLE, FILL, SLIDE, SHIFT, LOAD and DONE.
REQ-020 In IDLE, start=1 SHALL move the FSM to FILL on the next edge; start SHALL be ignored in every other state.
REQ-021 FILL SHALL read image rows 0..3, 4 words each, in order r=0..3, w=0..3, with mem_addr = BASE + 4*r + w.
REQ-022 The block SHALL keep mem_rd high and mem_addr constant until mem_valid=1; on the next edge it SHALL advance to the next word, or leave the state.
REQ-023 buf_we SHALL be combinational mem_rd & mem_valid, with buf_i equal to the target buffer row and buf_j = 4*w at that same cycle.
REQ-024 mem_valid received while mem_rd=0 SHALL be ignored.
REQ-025 After the 16th word in FILL, the FSM SHALL go to SLIDE with buf_j=3.
REQ-026 In SLIDE, buf_re and win_valid SHALL both be 1; buf_i is don't-care.
REQ-027 In SLIDE, buf_j SHALL hold until win_ready=1, then increment by 1; the sequence is j = 3..15, which is 13 windows per band.
REQ-028 On acceptance at j=15, the FSM SHALL go to DONE if the band count has reached ROWS-3, otherwise to SHIFT.
REQ-029 SHIFT SHALL last exactly 1 cycle with buf_shift=1, buf_we=0 and buf_re=0; it then goes to LOAD.
REQ-030 LOAD SHALL read the 4 words of the next image row r (r = band+3) into buffer row buf_i=3, following REQ-022 and REQ-023, and then return to SLIDE with buf_j=3.
REQ-031 buf_shift and buf_we SHALL never be high in the same cycle.
REQ-032 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-033 Total windows per image SHALL be (ROWS-3)*13, and total memory reads SHALL be ROWS*4.
REQ-034 Counters SHALL be sized for the ROWS maximum; the address arithmetic SHALL be done at ADDR_W width, modulo 2^ADDR_W.
REQ-035 win_ready held low SHALL stall SLIDE indefinitely with all outputs stable.

Reset
REQ-036 rst_n=0 SHALL, asynchronously at any state, force the FSM to IDLE and clear all counters.
REQ-037 While in reset, all outputs SHALL be 0, including mem_addr, buf_i and buf_j.
REQ-038 After rst_n is released, the first start SHALL be honoured on the first rising edge.
REQ-039 A reset during an outstanding mem_rd SHALL drop the request; a late mem_valid SHALL then be ignored per REQ-024.

Verification
REQ-040 ROWS=4, BASE=0, mem_valid tied high, win_ready tied high, start pulse -> 16 reads at addresses 0..15, one buf_we per cycle, then buf_j 3..15 over 13 cycles, done 1 cycle later, with no buf_shift.
REQ-041 ROWS=6, BASE=8 -> three bands, 39 windows, 2 buf_shift pulses, LOAD addresses 24..27 then 28..31, buf_i=3 on each LOAD write.
REQ-042 mem_valid delayed 3 cycles per request -> mem_rd and mem_addr held stable for 4 cycles per request, and exactly one buf_we per word.
REQ-043 win_ready low for 5 cycles at j=7 -> buf_j holds at 7 with win_valid=1, then resumes at 8.
REQ-044 rst_n pulsed low in LOAD mid-request -> all outputs 0 immediately; a subsequent start restarts the image from address BASE.
REQ-045 start asserted while busy -> ignored, with the window count unchanged and done pulsed exactly once.
